instruction_fetch_unit: RTL

Read-side initiator for instruction_memory_unit. It holds the program counter, issues one-word reads to instruction memory, absorbs the memory's one-cycle registered read latency, and presents fetched instructions downstream through a valid/ready handshake with a 2-entry buffer. It supports start/stop via run and PC redirect (branch/jump) with flush of stale fetches.

---
 rtl/imem_pkg.sv | 19 +
 rtl/fetch_skid_fifo.sv | 46 ++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction fetch path.
// Entries carry the fetched word together with its word address.
package imem_pkg;

  localparam int IMEM_ADDR_W      = 32;
  localparam int IMEM_WORD_W      = 32;
  localparam int FETCH_FIFO_DEPTH = 2;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_RUN
  } fetch_state_t;

  typedef struct packed {
    logic [IMEM_WORD_W-1:0] data;
    logic [IMEM_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order buffer between the memory response and the
// downstream handshake; flush empties it in one edge.
module fetch_skid_fifo
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [1:0]   count
);

  fetch_entry_t mem [FETCH_FIFO_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];

  // The credit rule upstream must keep a push from landing on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push && !pop)
      assert (count < 2'(FETCH_FIFO_DEPTH));
    if (!rst && !flush && pop)
      assert (count != 2'd0);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC sequencing, one-word reads to instruction memory and a buffered
// valid/ready instruction stream with redirect flush.
module instruction_fetch_unit
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        imem_en,
  output logic        imem_wen,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [IMEM_ADDR_W-1:0] pc_q;
  logic [IMEM_ADDR_W-1:0] inflight_pc_q;
  logic                   inflight_q;
  logic                   discard_q;

  logic         issue;
  logic         pop;
  logic         push;
  logic [2:0]   used;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t resp;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: if (run)  state_d = FETCH_RUN;
      FETCH_RUN:  if (!run) state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  // Slots already owed: buffered + in flight, less what leaves this cycle.
  assign used = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    issue = (state_q == FETCH_RUN) && run && !redirect_valid
            && (used < 3'(FETCH_FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      if (redirect_valid) pc_q <= redirect_pc;
      else if (issue)     pc_q <= pc_q + PC_INC;
      if (issue) inflight_pc_q <= pc_q;
      inflight_q <= issue;
      discard_q  <= redirect_valid && inflight_q;
    end
  end

  assign pop       = inst_valid && inst_ready;
  assign push      = inflight_q && !discard_q && !redirect_valid;
  assign resp.data = imem_data_out;
  assign resp.pc   = inflight_pc_q;

  fetch_skid_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (resp),
    .pop        (pop),
    .head_entry (head),
    .count      (count)
  );

  assign inst_valid   = (count != 2'd0);
  assign inst_data    = inst_valid ? head.data : '0;
  assign inst_pc      = inst_valid ? head.pc : '0;
  assign imem_en      = issue;
  assign imem_wen     = 1'b0;
  assign imem_addr    = pc_q;
  assign imem_data_in = '0;

endmodule
